// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends a 4-byte command frame over a UART byte TX
// and waits, with a timeout, for the one-byte reply from the UART RX.
module uart_cmd_master #(
  parameter logic [7:0]  HEADER  = 8'h55,
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       err,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_rdy,
  input  logic [7:0] rx_data,
  input  logic       rx_en
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TX_BUSY,
    TX_IDLE,
    WAIT_RSP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [7:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [1:0]  idx;
  logic [23:0] cnt;
  logic [7:0]  rsp_q;
  logic        tmo_q;
  logic        expire;
  logic [7:0]  frame_byte;

  logic       busy_d;
  logic       done_d;
  logic [7:0] result_d;
  logic       err_d;
  logic [7:0] tx_data_d;
  logic       tx_en_d;

  assign expire = (cnt == TIMEOUT - 24'd1);

  always_comb begin
    frame_byte = HEADER;
    unique case (idx)
      2'd0: frame_byte = HEADER;
      2'd1: frame_byte = op_q;
      2'd2: frame_byte = a_q;
      2'd3: frame_byte = b_q;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 8'h00;
      err     <= 1'b0;
      tx_data <= 8'h00;
      tx_en   <= 1'b0;
    end else begin
      state   <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      err     <= err_d;
      tx_data <= tx_data_d;
      tx_en   <= tx_en_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (start) state_d = SEND;
      SEND:     if (tx_rdy) state_d = TX_BUSY;
      TX_BUSY:  if (!tx_rdy) state_d = TX_IDLE;
      TX_IDLE: begin
        if (tx_rdy)
          state_d = (idx == 2'd3) ? WAIT_RSP : SEND;
      end
      WAIT_RSP: if (rx_en || expire) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // result/err move on the same edge that raises done
  always_comb begin
    busy_d    = busy;
    done_d    = 1'b0;
    result_d  = result;
    err_d     = err;
    tx_data_d = tx_data;
    tx_en_d   = 1'b0;
    unique case (state)
      IDLE: busy_d = start;
      SEND: begin
        if (tx_rdy) begin
          tx_en_d   = 1'b1;
          tx_data_d = frame_byte;
        end
      end
      DONE: begin
        done_d = 1'b1;
        err_d  = tmo_q;
        if (!tmo_q) result_d = rsp_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      op_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      idx   <= 2'd0;
      cnt   <= 24'd0;
      rsp_q <= 8'h00;
      tmo_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            idx  <= 2'd0;
          end
        end
        TX_IDLE: begin
          if (tx_rdy) begin
            if (idx == 2'd3) cnt <= 24'd0;
            else idx <= idx + 2'd1;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt + 24'd1;
          if (rx_en) begin
            rsp_q <= rx_data;
            tmo_q <= 1'b0;
          end else if (expire) begin
            tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
